// File: rtl/bus_master.sv
// 68000-style asynchronous bus initiator: turns a one-cycle request into an AS/UDS/LDS bus cycle.
// Optional ASSERT-phase timeout is compiled in with `define BUS_TIMEOUT_EN.
module bus_master #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        REQ,
   input  logic        REQ_RW,
   input  logic [23:1] REQ_ADDR,
   input  logic        REQ_UDS_EN,
   input  logic        REQ_LDS_EN,
   input  logic [15:0] REQ_WDATA,
   output logic        BUSY,
   output logic        DONE,
   output logic        ERR,
   output logic [15:0] RDATA,
   output logic [23:1] ADDR,
   output logic [15:0] DATA_OUT,
   output logic        DATA_OE,
   input  logic [15:0] DATA_IN,
   output logic        AS,
   output logic        UDS,
   output logic        LDS,
   output logic        RW,
   input  logic        DTACK,
   input  logic        BERR
);

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("bus_master: TIMEOUT_CYCLES must be in 1..255");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_ADDR,
      S_ASSERT,
      S_NEGATE
   } state_t;

   state_t      state, state_nxt;

   logic        dtack_m, dtack_s;
   logic        berr_m, berr_s;

   logic        uds_en, uds_en_nxt;
   logic        lds_en, lds_en_nxt;
   logic        err_flag, err_flag_nxt;

   logic        busy_nxt, done_nxt, err_nxt;
   logic [15:0] rdata_nxt;
   logic [23:1] addr_nxt;
   logic [15:0] dout_nxt;
   logic        oe_nxt;
   logic        as_nxt, uds_nxt, lds_nxt, rw_nxt;

`ifdef BUS_TIMEOUT_EN
   localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);
   logic [7:0]  tmo_cnt, tmo_cnt_nxt;
   logic [7:0]  tmo_cnt_inc;
   assign tmo_cnt_inc = tmo_cnt + 8'd1;
`endif

   // DTACK/BERR come from another clock domain; two flops each, idle high.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         dtack_m <= 1'b1;
         dtack_s <= 1'b1;
         berr_m  <= 1'b1;
         berr_s  <= 1'b1;
      end else begin
         dtack_m <= DTACK;
         dtack_s <= dtack_m;
         berr_m  <= BERR;
         berr_s  <= berr_m;
      end
   end

   always_comb begin
      state_nxt    = state;
      uds_en_nxt   = uds_en;
      lds_en_nxt   = lds_en;
      err_flag_nxt = err_flag;
      busy_nxt     = BUSY;
      done_nxt     = 1'b0;
      err_nxt      = 1'b0;
      rdata_nxt    = RDATA;
      addr_nxt     = ADDR;
      dout_nxt     = DATA_OUT;
      oe_nxt       = DATA_OE;
      as_nxt       = AS;
      uds_nxt      = UDS;
      lds_nxt      = LDS;
      rw_nxt       = RW;
`ifdef BUS_TIMEOUT_EN
      tmo_cnt_nxt  = tmo_cnt;
`endif

      case (state)
         S_IDLE: begin
            if (REQ) begin
               if (REQ_UDS_EN || REQ_LDS_EN) begin
                  uds_en_nxt   = REQ_UDS_EN;
                  lds_en_nxt   = REQ_LDS_EN;
                  err_flag_nxt = 1'b0;
                  addr_nxt     = REQ_ADDR;
                  dout_nxt     = REQ_WDATA;
                  rw_nxt       = REQ_RW;
                  oe_nxt       = ~REQ_RW;
                  busy_nxt     = 1'b1;
                  state_nxt    = S_ADDR;
               end else begin
                  // Nothing to transfer: report an error without touching the bus.
                  done_nxt = 1'b1;
                  err_nxt  = 1'b1;
               end
            end
         end

         S_ADDR: begin
            as_nxt    = 1'b0;
            uds_nxt   = ~uds_en;
            lds_nxt   = ~lds_en;
`ifdef BUS_TIMEOUT_EN
            tmo_cnt_nxt = 8'd0;
`endif
            state_nxt = S_ASSERT;
         end

         S_ASSERT: begin
            if (!berr_s) begin
               err_flag_nxt = 1'b1;
               state_nxt    = S_NEGATE;
            end else if (!dtack_s) begin
               if (RW) begin
                  rdata_nxt = DATA_IN;
               end
               state_nxt = S_NEGATE;
            end else begin
`ifdef BUS_TIMEOUT_EN
               // The count reaches the limit at the edge ending the last allowed ASSERT cycle.
               tmo_cnt_nxt = tmo_cnt_inc;
               if (tmo_cnt_inc == TMO_LIMIT) begin
                  err_flag_nxt = 1'b1;
                  state_nxt    = S_NEGATE;
               end
`endif
            end
            if (state_nxt == S_NEGATE) begin
               as_nxt  = 1'b1;
               uds_nxt = 1'b1;
               lds_nxt = 1'b1;
            end
         end

         S_NEGATE: begin
            // RW and write data were held one cycle past strobe negation for hold time.
            done_nxt  = 1'b1;
            err_nxt   = err_flag;
            busy_nxt  = 1'b0;
            rw_nxt    = 1'b1;
            oe_nxt    = 1'b0;
            state_nxt = S_IDLE;
         end

         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state    <= S_IDLE;
         uds_en   <= 1'b0;
         lds_en   <= 1'b0;
         err_flag <= 1'b0;
         BUSY     <= 1'b0;
         DONE     <= 1'b0;
         ERR      <= 1'b0;
         RDATA    <= '0;
         ADDR     <= '0;
         DATA_OUT <= '0;
         DATA_OE  <= 1'b0;
         AS       <= 1'b1;
         UDS      <= 1'b1;
         LDS      <= 1'b1;
         RW       <= 1'b1;
`ifdef BUS_TIMEOUT_EN
         tmo_cnt  <= 8'd0;
`endif
      end else begin
         state    <= state_nxt;
         uds_en   <= uds_en_nxt;
         lds_en   <= lds_en_nxt;
         err_flag <= err_flag_nxt;
         BUSY     <= busy_nxt;
         DONE     <= done_nxt;
         ERR      <= err_nxt;
         RDATA    <= rdata_nxt;
         ADDR     <= addr_nxt;
         DATA_OUT <= dout_nxt;
         DATA_OE  <= oe_nxt;
         AS       <= as_nxt;
         UDS      <= uds_nxt;
         LDS      <= lds_nxt;
         RW       <= rw_nxt;
`ifdef BUS_TIMEOUT_EN
         tmo_cnt  <= tmo_cnt_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_bus_master.sv
// Directed bench for bus_master: completions are checked against a scoreboard of expected ERR/RDATA.
module tb_bus_master;

   logic        CLK = 1'b0;
   logic        RST;
   logic        REQ;
   logic        REQ_RW;
   logic [23:1] REQ_ADDR;
   logic        REQ_UDS_EN;
   logic        REQ_LDS_EN;
   logic [15:0] REQ_WDATA;
   logic        BUSY;
   logic        DONE;
   logic        ERR;
   logic [15:0] RDATA;
   logic [23:1] ADDR;
   logic [15:0] DATA_OUT;
   logic        DATA_OE;
   logic [15:0] DATA_IN;
   logic        AS;
   logic        UDS;
   logic        LDS;
   logic        RW;
   logic        DTACK;
   logic        BERR;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        err;
      logic [15:0] rdata;
   } exp_t;

   exp_t sbq[$];

   bus_master #(.TIMEOUT_CYCLES(16)) dut (
      .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_RW(REQ_RW), .REQ_ADDR(REQ_ADDR),
      .REQ_UDS_EN(REQ_UDS_EN), .REQ_LDS_EN(REQ_LDS_EN), .REQ_WDATA(REQ_WDATA),
      .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .RDATA(RDATA), .ADDR(ADDR),
      .DATA_OUT(DATA_OUT), .DATA_OE(DATA_OE), .DATA_IN(DATA_IN),
      .AS(AS), .UDS(UDS), .LDS(LDS), .RW(RW), .DTACK(DTACK), .BERR(BERR)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic push_exp(input logic err, input logic [15:0] rdata);
      exp_t e;
      e.err   = err;
      e.rdata = rdata;
      sbq.push_back(e);
   endtask

   task automatic issue(input logic rw, input logic [23:1] addr, input logic uds_en,
                        input logic lds_en, input logic [15:0] wdata);
      REQ        = 1'b1;
      REQ_RW     = rw;
      REQ_ADDR   = addr;
      REQ_UDS_EN = uds_en;
      REQ_LDS_EN = lds_en;
      REQ_WDATA  = wdata;
   endtask

   // Steps through the accepting edge and on until DONE, counting edges and AS-low samples.
   task automatic run_to_done(input int max_cyc, output int cyc, output int as_low);
      cyc    = 0;
      as_low = 0;
      tick();
      REQ = 1'b0;
      cyc = 1;
      if (AS === 1'b0) as_low++;
      while (DONE !== 1'b1 && cyc < max_cyc) begin
         tick();
         cyc++;
         if (AS === 1'b0) as_low++;
      end
      chk("done_seen", 32'(DONE), 32'd1);
   endtask

   // Scoreboard: each DONE pops one expected completion.
   always @(negedge CLK) begin
      if (DONE === 1'b1) begin
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL unexpected_done observed=1 expected=0");
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("done_err", 32'(ERR), 32'(e.err));
            chk("done_rdata", 32'(RDATA), 32'(e.rdata));
         end
      end
   end

   initial begin
      int cyc;
      int as_low;
      int n;
      logic bad;

      RST = 1'b0; REQ = 1'b0; REQ_RW = 1'b1; REQ_ADDR = '0;
      REQ_UDS_EN = 1'b0; REQ_LDS_EN = 1'b0; REQ_WDATA = '0;
      DATA_IN = '0; DTACK = 1'b0; BERR = 1'b1;
      tick(); tick();
      chk("rst_as", 32'(AS), 32'd1);
      chk("rst_strobes", {30'd0, UDS, LDS}, 32'd3);
      chk("rst_rw", 32'(RW), 32'd1);
      chk("rst_ctl", {29'd0, DATA_OE, BUSY, DONE}, 32'd0);
      chk("rst_err", 32'(ERR), 32'd0);
      chk("rst_rdata", 32'(RDATA), 32'd0);
      chk("rst_addr", 32'(ADDR), 32'd0);
      chk("rst_dout", 32'(DATA_OUT), 32'd0);
      RST = 1'b1;
      tick(); tick();

      // Read with DTACK tied low.
      DATA_IN = 16'hBEEF;
      issue(1'b1, 23'h400000, 1'b1, 1'b1, 16'h0000);
      push_exp(1'b0, 16'hBEEF);
      tick();
      REQ = 1'b0;
      chk("rd_busy", 32'(BUSY), 32'd1);
      chk("rd_addr", 32'(ADDR), 32'h400000);
      chk("rd_rw_oe", {30'd0, RW, DATA_OE}, 32'd2);
      chk("rd_as_setup", 32'(AS), 32'd1);
      tick();
      chk("rd_strobes", {29'd0, AS, UDS, LDS}, 32'd0);
      tick();
      chk("rd_as_neg", 32'(AS), 32'd1);
      tick();
      chk("rd_done", 32'(DONE), 32'd1);
      chk("rd_busy_end", 32'(BUSY), 32'd0);
      tick();

      // Same read timed end to end: four edges to DONE, AS low for one cycle.
      issue(1'b1, 23'h400000, 1'b1, 1'b1, 16'h0000);
      push_exp(1'b0, 16'hBEEF);
      run_to_done(20, cyc, as_low);
      chk("rd_latency", 32'(cyc), 32'd4);
      chk("rd_as_low", 32'(as_low), 32'd1);
      tick();

      // Write, LDS only, DTACK arrives five cycles after AS.
      DTACK = 1'b1;
      tick(); tick(); tick();
      issue(1'b0, 23'h780000, 1'b0, 1'b1, 16'h00A5);
      push_exp(1'b0, 16'hBEEF);
      tick();
      REQ = 1'b0;
      chk("wr_setup", {30'd0, RW, DATA_OE}, 32'd1);
      chk("wr_dout", 32'(DATA_OUT), 32'h00A5);
      chk("wr_addr", 32'(ADDR), 32'h780000);
      tick();
      chk("wr_strobes", {29'd0, AS, UDS, LDS}, 32'd2);
      bad = 1'b0;
      repeat (5) begin
         tick();
         if (UDS !== 1'b1 || RW !== 1'b0 || AS !== 1'b0) bad = 1'b1;
      end
      chk("wr_wait_state", 32'(bad), 32'd0);
      DTACK = 1'b0;
      n = 0;
      while (AS !== 1'b1 && n < 10) begin
         tick();
         n++;
         if (AS === 1'b0 && (UDS !== 1'b1 || RW !== 1'b0)) bad = 1'b1;
      end
      chk("wr_dtack_latency", 32'(n), 32'd3);
      chk("wr_hold", {29'd0, UDS, LDS, bad}, 32'd6);
      chk("wr_negate_oe", {30'd0, DATA_OE, RW}, 32'd2);
      chk("wr_negate_dout", 32'(DATA_OUT), 32'h00A5);
      tick();
      chk("wr_done", 32'(DONE), 32'd1);
      chk("wr_release", {30'd0, DATA_OE, RW}, 32'd1);
      tick();

      // BERR and DTACK together: error, RDATA untouched.
      BERR = 1'b0;
      tick(); tick();
      DATA_IN = 16'h1234;
      issue(1'b1, 23'h000100, 1'b1, 1'b1, 16'h0000);
      push_exp(1'b1, 16'hBEEF);
      run_to_done(20, cyc, as_low);
      chk("berr_latency", 32'(cyc), 32'd4);
      BERR = 1'b1;
      tick();

      // No lane enabled: immediate error, bus untouched.
      issue(1'b1, 23'h000200, 1'b0, 1'b0, 16'h0000);
      push_exp(1'b1, 16'hBEEF);
      tick();
      REQ = 1'b0;
      chk("nolane_done", {30'd0, DONE, BUSY}, 32'd2);
      bad = 1'b0;
      repeat (4) begin
         if (AS !== 1'b1 || UDS !== 1'b1 || LDS !== 1'b1) bad = 1'b1;
         tick();
      end
      chk("nolane_strobes", 32'(bad), 32'd0);

      // No termination at all.
      DTACK = 1'b1;
      tick(); tick(); tick();
`ifdef BUS_TIMEOUT_EN
      issue(1'b1, 23'h000300, 1'b1, 1'b1, 16'h0000);
      push_exp(1'b1, 16'hBEEF);
      run_to_done(60, cyc, as_low);
      chk("tmo_as_low", 32'(as_low), 32'd16);
      chk("tmo_latency", 32'(cyc), 32'd19);
      tick();
`else
      issue(1'b1, 23'h000300, 1'b1, 1'b1, 16'h0000);
      tick();
      REQ = 1'b0;
      repeat (1000) tick();
      chk("hang_busy", 32'(BUSY), 32'd1);
      chk("hang_as", 32'(AS), 32'd0);
      RST = 1'b0;
      tick();
      RST = 1'b1;
      chk("hang_rst", {28'd0, AS, UDS, LDS, BUSY}, 32'he);
      tick();
`endif

      // Reset in the middle of a write's ASSERT phase.
      issue(1'b0, 23'h000400, 1'b1, 1'b1, 16'h5A5A);
      tick();
      REQ = 1'b0;
      tick(); tick(); tick();
      chk("mid_as", {30'd0, AS, DATA_OE}, 32'd1);
      RST = 1'b0;
      tick();
      RST = 1'b1;
      chk("mid_rst_strobes", {29'd0, AS, UDS, LDS}, 32'd7);
      chk("mid_rst_ctl", {29'd0, DATA_OE, BUSY, RW}, 32'd1);
      tick(); tick();

      // Recovery read after the aborted cycle.
      DTACK = 1'b0;
      tick(); tick();
      DATA_IN = 16'hCAFE;
      issue(1'b1, 23'h000500, 1'b1, 1'b1, 16'h0000);
      push_exp(1'b0, 16'hCAFE);
      run_to_done(20, cyc, as_low);
      chk("rec_latency", 32'(cyc), 32'd4);
      tick(); tick();

      chk("sb_empty", 32'(sbq.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
